// File: rtl/traffic_cmd_issuer.sv
// Command issuer for traffic_lights: validates host requests, queues them in a FIFO and replays
// them as single-cycle cmd_valid pulses separated by a fixed idle gap.
module traffic_cmd_issuer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CMD_GAP    = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [2:0]                      req_type_i,
    input  logic [15:0]                     req_data_i,
    input  logic                            flush_i,
    output logic                            cmd_valid_o,
    output logic [2:0]                      cmd_type_o,
    output logic [15:0]                     cmd_data_o,
    output logic                            busy_o,
    output logic                            err_o,
    output logic [$clog2(FIFO_DEPTH):0]     used_o
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned UsedW = PtrW + 1;
    localparam int unsigned GapW  = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam logic [UsedW-1:0] UsedFull = UsedW'(FIFO_DEPTH);
    localparam logic [GapW-1:0]  GapLast  = GapW'(CMD_GAP - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e            state_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              cmd_valid_q;
    logic [2:0]        cmd_type_q;
    logic [15:0]       cmd_data_q;

    logic [2:0]        type_mem [FIFO_DEPTH];
    logic [15:0]       data_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [UsedW-1:0]  used_q, used_d;
    logic              ready_q;
    logic              err_q;

    logic              xfer;
    logic              req_ok;
    logic              push;
    logic              pop;
    logic [15:0]       store_data;

    assign xfer = req_valid_i & ready_q;

    always_comb begin
        req_ok = 1'b0;
        unique case (req_type_i)
            3'd0, 3'd1, 3'd2: req_ok = 1'b1;
            3'd3, 3'd4, 3'd5: req_ok = (req_data_i != 16'd0);
            default:          req_ok = 1'b0;
        endcase
    end

    // Flush wins over a same-cycle push; the handshake still completes.
    assign push       = xfer & req_ok & ~flush_i;
    assign pop        = (state_q == StIssue) & ~flush_i;
    assign store_data = (req_type_i <= 3'd2) ? 16'd0 : req_data_i;

    always_comb begin
        used_d   = used_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            used_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) begin
                used_d = used_q + 1'b1;
            end else if (pop && !push) begin
                used_d = used_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            used_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            used_q   <= used_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= (used_d != UsedFull);
            err_q    <= xfer & ~req_ok & ~flush_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            type_mem[wr_ptr_q] <= req_type_i;
            data_mem[wr_ptr_q] <= store_data;
        end
    end

    // Outputs are loaded on entry to StIssue; the head is popped on leaving it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            gap_cnt_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= 3'd0;
            cmd_data_q  <= 16'd0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= 3'd0;
            cmd_data_q  <= 16'd0;
            if (flush_i) begin
                if (state_q != StIdle) begin
                    state_q   <= StGap;
                    gap_cnt_q <= '0;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (used_q != '0) begin
                            state_q     <= StIssue;
                            cmd_valid_q <= 1'b1;
                            cmd_type_q  <= type_mem[rd_ptr_q];
                            cmd_data_q  <= data_mem[rd_ptr_q];
                        end
                    end
                    StIssue: begin
                        state_q   <= StGap;
                        gap_cnt_q <= '0;
                    end
                    StGap: begin
                        if (gap_cnt_q == GapLast) begin
                            if (used_q != '0) begin
                                state_q     <= StIssue;
                                cmd_valid_q <= 1'b1;
                                cmd_type_q  <= type_mem[rd_ptr_q];
                                cmd_data_q  <= data_mem[rd_ptr_q];
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign req_ready_o = ready_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign busy_o      = (used_q != '0) | (state_q != StIdle);
    assign err_o       = err_q;
    assign used_o      = used_q;

endmodule

// File: tb/tb_traffic_cmd_issuer.sv
// Directed bench for traffic_cmd_issuer: latency, spacing, backpressure, validation, flush, reset.
module tb_traffic_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [15:0] req_data;
    logic        flush;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [15:0] cmd_data;
    logic        busy;
    logic        err;
    logic [2:0]  used;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    int stall_cnt = 0;
    int max_used  = 0;
    int viol_cnt  = 0;
    int err_cnt   = 0;

    logic [2:0]  p_type [$];
    logic [15:0] p_data [$];
    int          p_cyc  [$];

    traffic_cmd_issuer #(.FIFO_DEPTH(4), .CMD_GAP(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_type_i  (req_type),
        .req_data_i  (req_data),
        .flush_i     (flush),
        .cmd_valid_o (cmd_valid),
        .cmd_type_o  (cmd_type),
        .cmd_data_o  (cmd_data),
        .busy_o      (busy),
        .err_o       (err),
        .used_o      (used)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmd_valid) begin
            p_type.push_back(cmd_type);
            p_data.push_back(cmd_data);
            p_cyc.push_back(cyc);
        end else if (cmd_type != 3'd0 || cmd_data != 16'd0) begin
            viol_cnt = viol_cnt + 1;
        end
        if (used > 3'd4) viol_cnt = viol_cnt + 1;
        if (used == 3'd4 && req_ready) viol_cnt = viol_cnt + 1;
        if (int'(used) > max_used) max_used = int'(used);
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        p_type.delete();
        p_data.delete();
        p_cyc.delete();
    endtask

    task automatic push(input logic [2:0] t, input logic [15:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_type  = t;
        req_data  = d;
        while (!req_ready && n < 100) begin
            tick();
            n++;
            stall_cnt++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: req_ready_o stayed %0b, required 1", req_ready);
        end
        tick();
        last_acc  = cyc;
        req_valid = 1'b0;
        req_type  = 3'd0;
        req_data  = 16'd0;
    endtask

    task automatic wait_pulses(input int n);
        int k;
        k = 0;
        while (p_type.size() < n && k < 200) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout: busy_o=%0b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({cmd_valid, cmd_type, cmd_data, busy, err, used, req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b type=%0d data=%0d busy=%0b err=%0b used=%0d ready=%0b, required all 0",
                     cmd_valid, cmd_type, cmd_data, busy, err, used, req_ready);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: req_ready_o=%0b, required 1", req_ready);
        end
    endtask

    task automatic test_single();
        int acc;
        clear_log();
        push(3'd4, 16'd10);
        acc = last_acc;
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: cmd_valid_o=%0b at accept edge, required 0", cmd_valid);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_type !== 3'd4 || cmd_data !== 16'd10) begin
            failures++;
            $display("FAIL single_pulse: valid=%0b type=%0d data=%0d, required 1/4/10",
                     cmd_valid, cmd_type, cmd_data);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_gap: valid=%0b busy=%0b, required 0/1", cmd_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_gap: busy_o=%0b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_clear: busy_o=%0b, required 0", busy);
        end
        checks++;
        if (p_cyc.size() != 1 || p_cyc[0] != acc + 1) begin
            failures++;
            $display("FAIL single_count: pulses=%0d, required 1 at edge %0d", p_cyc.size(), acc + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  et [4];
        logic [15:0] ed [4];
        int acc0;
        et = '{3'd4, 3'd5, 3'd3, 3'd0};
        ed = '{16'd10, 16'd10, 16'd10, 16'd0};
        clear_log();
        push(3'd4, 16'd10);
        acc0 = last_acc;
        push(3'd5, 16'd10);
        push(3'd3, 16'd10);
        push(3'd0, 16'd7);
        wait_pulses(4);
        checks++;
        if (p_type.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: pulses=%0d, required 4", p_type.size());
        end else begin
            checks++;
            if (p_cyc[0] != acc0 + 1) begin
                failures++;
                $display("FAIL b2b_latency: first pulse edge %0d, required %0d", p_cyc[0], acc0 + 1);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (p_type[i] !== et[i] || p_data[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL b2b_order[%0d]: type=%0d data=%0d, required %0d/%0d",
                             i, p_type[i], p_data[i], et[i], ed[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (p_cyc[i] - p_cyc[i-1] != 3) begin
                        failures++;
                        $display("FAIL b2b_spacing[%0d]: %0d cycles, required 3",
                                 i, p_cyc[i] - p_cyc[i-1]);
                    end
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_full_stall();
        logic [2:0]  et [6];
        logic [15:0] ed [6];
        logic [15:0] din [6];
        et  = '{3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
        din = '{16'd100, 16'd101, 16'd102, 16'd103, 16'd104, 16'd105};
        ed  = '{16'd100, 16'd101, 16'd102, 16'd0, 16'd0, 16'd0};
        clear_log();
        stall_cnt = 0;
        max_used  = 0;
        for (int i = 0; i < 6; i++) push(et[i], din[i]);
        wait_pulses(6);
        checks++;
        if (max_used != 4 || stall_cnt == 0) begin
            failures++;
            $display("FAIL full_stall: max_used=%0d stalls=%0d, required 4 and >0", max_used, stall_cnt);
        end
        checks++;
        if (p_type.size() != 6) begin
            failures++;
            $display("FAIL full_count: pulses=%0d, required 6", p_type.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (p_type[i] !== et[i] || p_data[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL full_order[%0d]: type=%0d data=%0d, required %0d/%0d",
                             i, p_type[i], p_data[i], et[i], ed[i]);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_validation();
        clear_log();
        err_cnt = 0;
        push(3'd3, 16'd0);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_zero_data: err_o=%0b, required 1", err);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_one_cycle: err_o=%0b, required 0", err);
        end
        push(3'd7, 16'd50);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_bad_type: err_o=%0b, required 1", err);
        end
        repeat (8) tick();
        checks++;
        if (p_type.size() != 0 || used !== 3'd0 || err_cnt != 2) begin
            failures++;
            $display("FAIL err_no_issue: pulses=%0d used=%0d errs=%0d, required 0/0/2",
                     p_type.size(), used, err_cnt);
        end
        push(3'd0, 16'hABCD);
        wait_pulses(1);
        checks++;
        if (p_type.size() != 1 || p_type[0] !== 3'd0 || p_data[0] !== 16'd0) begin
            failures++;
            $display("FAIL on_data_zero: pulses=%0d data=%h, required 1 pulse data 0000",
                     p_type.size(), (p_data.size() > 0) ? p_data[0] : 16'hxxxx);
        end
        wait_idle();
    endtask

    task automatic test_flush();
        clear_log();
        push(3'd4, 16'd1);
        push(3'd4, 16'd2);
        push(3'd4, 16'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (used !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty: used=%0d busy=%0b, required 0/1", used, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_gap: busy_o=%0b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy_clear: busy_o=%0b, required 0", busy);
        end
        repeat (10) tick();
        checks++;
        if (p_type.size() != 1 || p_data[0] !== 16'd1) begin
            failures++;
            $display("FAIL flush_pulses: pulses=%0d, required 1", p_type.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        push(3'd5, 16'd4);
        push(3'd5, 16'd5);
        push(3'd5, 16'd6);
        checks++;
        if (used !== 3'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: used=%0d busy=%0b, required 2/1", used, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || used !== 3'd0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: valid=%0b busy=%0b used=%0d ready=%0b, required 0/0/0/0",
                     cmd_valid, busy, used, req_ready);
        end
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        checks++;
        if (p_type.size() != 1 || used !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_after: pulses=%0d used=%0d busy=%0b, required 1/0/0",
                     p_type.size(), used, busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_type  = 3'd0;
        req_data  = 16'd0;
        flush     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_validation();
        test_flush();
        test_reset_mid();
        checks++;
        if (viol_cnt != 0) begin
            failures++;
            $display("FAIL invariants: violations=%0d, required 0", viol_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
